led_pattern_ctrl: RTL and testbench



---
 rtl/led_pattern_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer for the ULX3S. Four pattern generators (binary counter,
// scanner, blink, button mirror) share the LED bank. Debounced btn[3]/btn[4]
// step the pattern forward/backward and debounced btn[2] freezes advance.
//
// Ports:
//   i_clk    system clock (clk_25mhz)
//   i_rst_n  asynchronous active-low reset
//   i_btn    raw buttons, asynchronous, active-high
//   o_led    registered LED drive
//   o_mode   current pattern: 0 BINARY, 1 SCAN, 2 BLINK, 3 MIRROR
//   o_tick   one-cycle pulse every TICK_DIV cycles
module led_pattern_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TICK_DIV        = 3125000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_btn,
  output logic [7:0] o_led,
  output logic [1:0] o_mode,
  output logic       o_tick
);

  localparam int unsigned DbW   = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TickW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
  localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ModeBinary = 2'd0,
    ModeScan   = 2'd1,
    ModeBlink  = 2'd2,
    ModeMirror = 2'd3
  } mode_e;

  // Debounced button indices.
  localparam int unsigned BtnFreeze = 0;
  localparam int unsigned BtnNext   = 1;
  localparam int unsigned BtnPrev   = 2;

  // 2-FF synchronizer for every raw button.
  logic [6:0] btn_meta_q, btn_sync_q;

  // Debouncers
  logic [2:0]          db_in;
  logic [2:0]          db_q, db_d;
  logic [2:0]          db_prev_q;
  logic [2:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]          press_q, press_d;

  // Tick generator
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_q, tick_d;

  // Mode FSM and pattern state
  mode_e      mode_q, mode_d;
  logic [7:0] count_q, count_d;
  logic [2:0] pos_q, pos_d;
  logic       dir_q, dir_d;  // 0 = up, 1 = down
  logic       phase_q, phase_d;
  logic [7:0] led_q, led_d;

  logic mode_chg;
  logic frozen;

  assign db_in = {btn_sync_q[4], btn_sync_q[3], btn_sync_q[2]};

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      // Counter only runs while the synced level disagrees with the debounced one.
      if (db_in[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          db_d[i] = db_in[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases produce nothing.
  assign press_d = db_q & ~db_prev_q;

  always_comb begin
    tick_d     = 1'b0;
    tick_cnt_d = tick_cnt_q + TickW'(1);
    if (tick_cnt_q == TickMax) begin
      tick_d     = 1'b1;
      tick_cnt_d = '0;
    end
  end

  // next and prev pulsing together cancel out.
  assign mode_chg = press_q[BtnNext] ^ press_q[BtnPrev];
  assign frozen   = db_q[BtnFreeze];

  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;

    if (mode_chg) begin
      if (press_q[BtnNext]) begin
        mode_d = mode_e'(mode_q + 2'd1);
      end else begin
        mode_d = mode_e'(mode_q - 2'd1);
      end
      // A mode change wins over a coincident tick: state restarts cleanly.
      count_d = '0;
      pos_d   = '0;
      dir_d   = 1'b0;
      phase_d = 1'b0;
    end else if (tick_q && !frozen) begin
      unique case (mode_q)
        ModeBinary: count_d = count_q + 8'd1;
        ModeScan: begin
          if (!dir_q) begin
            pos_d = pos_q + 3'd1;
            if (pos_q == 3'd6) dir_d = 1'b1;
          end else begin
            pos_d = pos_q - 3'd1;
            if (pos_q == 3'd1) dir_d = 1'b0;
          end
        end
        ModeBlink, ModeMirror: phase_d = ~phase_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    unique case (mode_q)
      ModeBinary: led_d = count_q;
      ModeScan:   led_d = 8'h01 << pos_q;
      ModeBlink:  led_d = phase_q ? 8'hFF : 8'h00;
      ModeMirror: led_d = {phase_q, btn_sync_q};
      default:    led_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      db_cnt_q   <= '0;
      press_q    <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      mode_q     <= ModeBinary;
      count_q    <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      phase_q    <= 1'b0;
      led_q      <= '0;
    end else begin
      btn_meta_q <= i_btn;
      btn_sync_q <= btn_meta_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      phase_q    <= phase_d;
      led_q      <= led_d;
    end
  end

  assign o_led  = led_q;
  assign o_mode = mode_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed testbench for led_pattern_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=8.
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] btn;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  int n_checks;
  int n_fail;

  logic [7:0] scan_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};

  led_pattern_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (8)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_btn  (btn),
    .o_led  (led),
    .o_mode (mode),
    .o_tick (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset then release just after an edge; the next edge is cycle 1.
  task automatic do_reset();
    btn   = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_led(input logic [7:0] v, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (led === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    btn   = '0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if (led !== 8'h00 || mode !== 2'd0 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: led=%h mode=%0d tick=%b expected 00 0 0", led, mode, tick);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_binary();
    logic [7:0] exp_led;
    for (int k = 1; k <= 42; k++) begin
      step();
      exp_led = (k >= 2) ? 8'((k - 2) / 8) : 8'd0;
      n_checks++;
      if (tick !== ((k % 8) == 0)) begin
        n_fail++;
        $display("FAIL binary_tick cycle %0d: tick=%b expected %b", k, tick, (k % 8) == 0);
      end
      n_checks++;
      if (led !== exp_led) begin
        n_fail++;
        $display("FAIL binary_led cycle %0d: led=%h expected %h", k, led, exp_led);
      end
    end
    n_checks++;
    if (mode !== 2'd0) begin
      n_fail++;
      $display("FAIL binary_mode: mode=%0d expected 0", mode);
    end
  endtask

  task automatic test_scan();
    logic [7:0] last;
    int         idx;
    int         k;
    btn = 7'h08;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 7) begin
        n_checks++;
        if (mode !== 2'd0) begin
          n_fail++;
          $display("FAIL scan_mode_early: mode=%0d expected 0", mode);
        end
      end
    end
    n_checks++;
    if (mode !== 2'd1) begin
      n_fail++;
      $display("FAIL scan_mode_latency: mode=%0d expected 1", mode);
    end
    step();
    n_checks++;
    if (led !== 8'h01) begin
      n_fail++;
      $display("FAIL scan_first_led: led=%h expected 01", led);
    end
    last = 8'h01;
    idx  = 0;
    k    = 9;
    while (idx < 8 && k < 120) begin
      step();
      k++;
      if (k == 20) btn = '0;
      if (led !== last) begin
        n_checks++;
        if (led !== scan_exp[idx]) begin
          n_fail++;
          $display("FAIL scan_step %0d: led=%h expected %h", idx, led, scan_exp[idx]);
        end
        last = led;
        idx++;
      end
    end
    btn = '0;
    n_checks++;
    if (idx < 8) begin
      n_fail++;
      $display("FAIL scan_timeout: saw %0d steps expected 8", idx);
    end
    n_checks++;
    if (mode !== 2'd1) begin
      n_fail++;
      $display("FAIL scan_mode_once: mode=%0d expected 1", mode);
    end
  endtask

  task automatic test_glitch_prev();
    do_reset();
    btn = 7'h08;
    repeat (3) step();
    btn = '0;
    repeat (15) step();
    n_checks++;
    if (mode !== 2'd0) begin
      n_fail++;
      $display("FAIL glitch_ignored: mode=%0d expected 0", mode);
    end
    btn = 7'h10;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 7 || c == 8) begin
        n_checks++;
        if (mode !== ((c == 7) ? 2'd0 : 2'd3)) begin
          n_fail++;
          $display("FAIL prev_wrap cycle %0d: mode=%0d expected %0d", c, mode,
                   (c == 7) ? 0 : 3);
        end
      end
    end
    btn = '0;
    repeat (10) step();
    n_checks++;
    if (mode !== 2'd3) begin
      n_fail++;
      $display("FAIL prev_release: mode=%0d expected 3", mode);
    end
  endtask

  task automatic test_both();
    bit         ok;
    logic [7:0] last;
    do_reset();
    wait_led(8'd2, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL both_setup: led=%h expected 02", led);
    end
    last = led;
    btn  = 7'h18;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 10) btn = '0;
      n_checks++;
      if (mode !== 2'd0) begin
        n_fail++;
        $display("FAIL both_mode cycle %0d: mode=%0d expected 0", k, mode);
      end
      if (led !== last) begin
        n_checks++;
        if (led !== last + 8'd1) begin
          n_fail++;
          $display("FAIL both_count: led=%h expected %h", led, last + 8'd1);
        end
        last = led;
      end
    end
    n_checks++;
    if (led !== 8'd7) begin
      n_fail++;
      $display("FAIL both_final: led=%h expected 07", led);
    end
  endtask

  task automatic test_freeze();
    bit ok;
    do_reset();
    wait_led(8'd4, 60, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL freeze_setup: led=%h expected 04", led);
    end
    wait_tick(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL freeze_tick_timeout: tick=%b expected 1", tick);
    end
    btn = 7'h04;
    for (int k = 1; k <= 42; k++) begin
      step();
      if (k == 30) btn = '0;
      if (k >= 2 && k <= 41) begin
        n_checks++;
        if (led !== 8'd5) begin
          n_fail++;
          $display("FAIL freeze_hold cycle %0d: led=%h expected 05", k, led);
        end
      end else if (k == 42) begin
        n_checks++;
        if (led !== 8'd6) begin
          n_fail++;
          $display("FAIL freeze_resume: led=%h expected 06", led);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    wait_led(8'hFF, 2200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wrap_setup: led=%h expected ff", led);
    end
    repeat (7) step();
    n_checks++;
    if (led !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_before: led=%h expected ff", led);
    end
    step();
    n_checks++;
    if (led !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_zero: led=%h expected 00", led);
    end
  endtask

  task automatic test_mirror_reset();
    bit   ok;
    logic b0;
    logic b1;
    do_reset();
    btn = 7'h10;
    repeat (10) step();
    n_checks++;
    if (mode !== 2'd3) begin
      n_fail++;
      $display("FAIL mirror_mode: mode=%0d expected 3", mode);
    end
    btn = 7'h51;
    repeat (3) step();
    n_checks++;
    if (led[6:0] !== 7'h51) begin
      n_fail++;
      $display("FAIL mirror_track: led[6:0]=%h expected 51", led[6:0]);
    end
    wait_tick(ok);
    step();
    step();
    b0 = led[7];
    for (int i = 1; i <= 2; i++) begin
      wait_tick(ok);
      step();
      step();
      n_checks++;
      if (!ok || led !== {b0 ^ logic'(i % 2), 7'h51}) begin
        n_fail++;
        $display("FAIL mirror_phase %0d: led=%h expected %h", i, led, {b0 ^ logic'(i % 2), 7'h51});
      end
    end
    btn = 7'h55;
    repeat (10) step();
    b1 = led[7];
    n_checks++;
    if (led[6:0] !== 7'h55) begin
      n_fail++;
      $display("FAIL mirror_track55: led[6:0]=%h expected 55", led[6:0]);
    end
    wait_tick(ok);
    step();
    step();
    n_checks++;
    if (!ok || led !== {b1, 7'h55}) begin
      n_fail++;
      $display("FAIL mirror_frozen: led=%h expected %h", led, {b1, 7'h55});
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led !== 8'h00 || mode !== 2'd0 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: led=%h mode=%0d tick=%b expected 00 0 0", led, mode, tick);
    end
    btn = '0;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    n_checks++;
    if (led !== 8'd1 || mode !== 2'd0) begin
      n_fail++;
      $display("FAIL restart: led=%h mode=%0d expected 01 0", led, mode);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    btn      = '0;
    rst_n    = 1'b1;
    test_reset();
    test_binary();
    test_scan();
    test_glitch_prev();
    test_both();
    test_freeze();
    test_wrap();
    test_mirror_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
